// File: rtl/key_entry_controller_pkg.sv
// Shared definitions for the keypad-to-calculator path: key codes, operator codes,
// display special words, display limits and the entry state enum.
package calc_pkg;

  localparam logic [4:0] KEY_IDLE   = 5'h1F;
  localparam logic [4:0] KEY_EQ     = 5'h16;
  localparam logic [4:0] KEY_SIGN   = 5'h17;
  localparam logic [4:0] KEY_CLR    = 5'h18;
  localparam logic [4:0] KEY_ANS    = 5'h19;
  localparam logic [4:0] KEY_OP_MUL = 5'h11;
  localparam logic [4:0] KEY_OP_MOD = 5'h15;

  localparam logic [2:0] OPR_MUL = 3'd1;
  localparam logic [2:0] OPR_DIV = 3'd2;
  localparam logic [2:0] OPR_ADD = 3'd3;
  localparam logic [2:0] OPR_SUB = 3'd4;
  localparam logic [2:0] OPR_MOD = 3'd5;

  localparam logic [31:0] DISP_ERR      = 32'h00EE_0000;
  localparam logic [31:0] DISP_ANS      = 32'h00B0_0000;
  localparam logic [31:0] DISP_NEG_ANS  = 32'hE0B0_0000;
  localparam logic [31:0] DISP_NEG_ZERO = 32'hE000_0000;

  localparam int signed DISP_MAX = 999999;
  localparam int signed DISP_MIN = -99999;

  typedef enum logic [2:0] {
    S_OP1,
    S_OPR,
    S_OP2,
    S_CALC,
    S_RESULT,
    S_ERROR
  } state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return code <= 5'h09;
  endfunction

  function automatic logic is_op(input logic [4:0] code);
    return (code >= KEY_OP_MUL) && (code <= KEY_OP_MOD);
  endfunction

  // Operator symbol word: operator code in bits [22:20]
  function automatic logic [31:0] opr_disp(input logic [2:0] opr);
    return {9'h000, opr, 20'h00000};
  endfunction

endpackage

// File: rtl/key_entry_controller_if.sv
// Bus between keypad/calculator environment and key_entry_controller.
interface key_entry_controller_if;
  logic [4:0]  eBCD;
  logic [31:0] ans;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  operator;
  logic [31:0] fnd_serial;

  modport master (
    output eBCD, ans,
    input  operand1, operand2, operator, fnd_serial
  );

  modport slave (
    input  eBCD, ans,
    output operand1, operand2, operator, fnd_serial
  );
endinterface

// File: rtl/key_entry_controller_key_strobe.sv
// Idle-to-key edge detector: one-cycle strobe when eBCD leaves the idle code.
module key_strobe
  import calc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_code,
  output logic       o_key_valid,
  output logic [4:0] o_key_code
);
  logic [4:0] r_prev;

  // Remember last cycle's code so held keys and code-to-code glides are not re-accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= KEY_IDLE;
    else       r_prev <= i_code;
  end

  // Strobe only on the idle -> non-idle transition
  always_comb begin
    o_key_valid = (r_prev == KEY_IDLE) && (i_code != KEY_IDLE);
    o_key_code  = i_code;
  end
endmodule

// File: rtl/key_entry_controller.sv
// Key entry controller: assembles operand1/operator/operand2 from keypad codes,
// waits CALC_LATENCY for calculate, captures ans and drives the display word.
// Optional macro KEY_ANS_RECALL_EN adds the ANS recall key (5'h19).
module key_entry_controller
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS   = 6,
  parameter int unsigned CALC_LATENCY = 1
) (
  input logic                   sw_clk,
  input logic                   rst,
  key_entry_controller_if.slave bus
);
  localparam int unsigned       CNT_W    = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]  POS_LIM  = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]  NEG_LIM  = CNT_W'(MAX_DIGITS - 1);
  localparam logic [15:0]       LAT_INIT = 16'(CALC_LATENCY);

  state_t           r_state, w_state_n;
  logic [31:0]      r_mag, w_mag_n;
  logic             r_neg, w_neg_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [31:0]      r_op1, w_op1_n;
  logic [31:0]      r_op2, w_op2_n;
  logic [2:0]       r_opr, w_opr_n;
  logic [31:0]      r_fnd, w_fnd_n;
  logic [15:0]      r_lat, w_lat_n;

  logic             w_key_valid;
  logic [4:0]       w_key_code;
  logic             w_key_clear;
  logic             w_lock, w_lock_n;
  logic [31:0]      w_chain;
  logic [31:0]      w_value;
  logic [31:0]      w_mag_app;
  logic [CNT_W-1:0] w_lim;
  logic             w_calc_err;
  logic             w_capture;

  key_strobe u_key_strobe (
    .i_clk       (sw_clk),
    .i_rst       (rst),
    .i_code      (bus.eBCD),
    .o_key_valid (w_key_valid),
    .o_key_code  (w_key_code)
  );

  function automatic logic [31:0] entry_disp(input logic [31:0] mag, input logic neg,
                                             input logic lock);
    if (lock)              return neg ? DISP_NEG_ANS : DISP_ANS;
    if (neg && mag == '0)  return DISP_NEG_ZERO;
    return neg ? (32'd0 - mag) : mag;
  endfunction

  assign w_key_clear = w_key_valid && (w_key_code == KEY_CLR);
  assign w_value     = r_neg ? (32'd0 - r_mag) : r_mag;
  assign w_mag_app   = r_mag * 32'd10 + {27'd0, w_key_code};
  assign w_lim       = r_neg ? NEG_LIM : POS_LIM;
  assign w_capture   = (r_state == S_CALC) && (r_lat == '0);
  assign w_calc_err  = (((r_opr == OPR_DIV) || (r_opr == OPR_MOD)) && (r_op2 == '0)) ||
                       ($signed(bus.ans) > DISP_MAX) || ($signed(bus.ans) < DISP_MIN);

`ifdef KEY_ANS_RECALL_EN
  logic        r_lock;
  logic [31:0] r_last_ans, w_last_ans_n;

  assign w_lock  = r_lock;
  assign w_chain = r_last_ans;

  // Last good result survives the clear key; only rst wipes it
  always_comb begin
    w_last_ans_n = r_last_ans;
    if (w_capture && !w_key_clear && !w_calc_err) w_last_ans_n = bus.ans;
  end

  // Recall lock and last-ans registers
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_last_ans <= '0;
    end else begin
      r_lock     <= w_lock_n;
      r_last_ans <= w_last_ans_n;
    end
  end
`else
  assign w_lock  = 1'b0;
  assign w_chain = r_fnd;
`endif

  // Entry state and datapath registers
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      r_state <= S_OP1;
      r_mag   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_opr   <= OPR_ADD;
      r_fnd   <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_n;
      r_mag   <= w_mag_n;
      r_neg   <= w_neg_n;
      r_cnt   <= w_cnt_n;
      r_op1   <= w_op1_n;
      r_op2   <= w_op2_n;
      r_opr   <= w_opr_n;
      r_fnd   <= w_fnd_n;
      r_lat   <= w_lat_n;
    end
  end

  // Key decode, accumulator edits and display selection per state
  always_comb begin
    w_state_n = r_state;
    w_mag_n   = r_mag;
    w_neg_n   = r_neg;
    w_cnt_n   = r_cnt;
    w_op1_n   = r_op1;
    w_op2_n   = r_op2;
    w_opr_n   = r_opr;
    w_fnd_n   = r_fnd;
    w_lat_n   = r_lat;
    w_lock_n  = w_lock;

    if (w_key_clear) begin
      w_state_n = S_OP1;
      w_mag_n   = '0;
      w_neg_n   = 1'b0;
      w_cnt_n   = '0;
      w_op1_n   = '0;
      w_op2_n   = '0;
      w_opr_n   = OPR_ADD;
      w_fnd_n   = '0;
      w_lat_n   = '0;
      w_lock_n  = 1'b0;
    end else begin
      unique case (r_state)
        S_OP1, S_OP2: begin
          if (w_key_valid) begin
            if (is_digit(w_key_code)) begin
              if (!w_lock && (r_cnt < w_lim)) begin
                w_mag_n = w_mag_app;
                if (!((r_mag == '0) && (w_key_code == 5'h00))) w_cnt_n = r_cnt + CNT_W'(1);
                w_fnd_n = entry_disp(w_mag_n, w_neg_n, w_lock_n);
              end
            end else if (w_key_code == KEY_SIGN) begin
              if (r_neg)               w_neg_n = 1'b0;
              else if (r_cnt <= NEG_LIM) w_neg_n = 1'b1;
              w_fnd_n = entry_disp(w_mag_n, w_neg_n, w_lock_n);
            end else if (is_op(w_key_code) && (r_state == S_OP1)) begin
              w_op1_n   = w_value;
              w_opr_n   = w_key_code[2:0];
              w_mag_n   = '0;
              w_neg_n   = 1'b0;
              w_cnt_n   = '0;
              w_lock_n  = 1'b0;
              w_fnd_n   = opr_disp(w_key_code[2:0]);
              w_state_n = S_OPR;
            end else if ((w_key_code == KEY_EQ) && (r_state == S_OP2)) begin
              w_op2_n   = w_value;
              w_lat_n   = LAT_INIT;
              w_lock_n  = 1'b0;
              w_state_n = S_CALC;
            end
`ifdef KEY_ANS_RECALL_EN
            else if (w_key_code == KEY_ANS) begin
              w_neg_n  = r_last_ans[31];
              w_mag_n  = r_last_ans[31] ? (32'd0 - r_last_ans) : r_last_ans;
              w_cnt_n  = '0;
              w_lock_n = 1'b1;
              w_fnd_n  = entry_disp(w_mag_n, w_neg_n, w_lock_n);
            end
`endif
          end
        end

        S_OPR: begin
          if (w_key_valid) begin
            if (is_op(w_key_code)) begin
              w_opr_n = w_key_code[2:0];
              w_fnd_n = opr_disp(w_key_code[2:0]);
            end else if (is_digit(w_key_code)) begin
              w_mag_n   = {27'd0, w_key_code};
              w_neg_n   = 1'b0;
              w_cnt_n   = (w_key_code == 5'h00) ? '0 : CNT_W'(1);
              w_fnd_n   = entry_disp(w_mag_n, w_neg_n, w_lock_n);
              w_state_n = S_OP2;
            end else if (w_key_code == KEY_SIGN) begin
              w_mag_n   = '0;
              w_neg_n   = 1'b1;
              w_cnt_n   = '0;
              w_fnd_n   = DISP_NEG_ZERO;
              w_state_n = S_OP2;
            end
`ifdef KEY_ANS_RECALL_EN
            else if (w_key_code == KEY_ANS) begin
              w_neg_n   = r_last_ans[31];
              w_mag_n   = r_last_ans[31] ? (32'd0 - r_last_ans) : r_last_ans;
              w_cnt_n   = '0;
              w_lock_n  = 1'b1;
              w_fnd_n   = entry_disp(w_mag_n, w_neg_n, w_lock_n);
              w_state_n = S_OP2;
            end
`endif
          end
        end

        S_CALC: begin
          if (w_capture) begin
            if (w_calc_err) begin
              w_fnd_n   = DISP_ERR;
              w_state_n = S_ERROR;
            end else begin
              w_fnd_n   = bus.ans;
              w_state_n = S_RESULT;
            end
          end else begin
            w_lat_n = r_lat - 16'd1;
          end
        end

        S_RESULT: begin
          if (w_key_valid) begin
            if (is_digit(w_key_code)) begin
              w_mag_n   = {27'd0, w_key_code};
              w_neg_n   = 1'b0;
              w_cnt_n   = (w_key_code == 5'h00) ? '0 : CNT_W'(1);
              w_lock_n  = 1'b0;
              w_fnd_n   = entry_disp(w_mag_n, w_neg_n, w_lock_n);
              w_state_n = S_OP1;
            end else if (is_op(w_key_code)) begin
              w_op1_n   = w_chain;
              w_opr_n   = w_key_code[2:0];
              w_fnd_n   = opr_disp(w_key_code[2:0]);
              w_state_n = S_OPR;
            end
          end
        end

        S_ERROR: begin
        end

        default: w_state_n = S_OP1;
      endcase
    end
  end

  assign bus.operand1   = r_op1;
  assign bus.operand2   = r_op2;
  assign bus.operator   = r_opr;
  assign bus.fnd_serial = r_fnd;
endmodule

// File: tb/tb_key_entry_controller.sv
// Self-checking bench for key_entry_controller (default build, no ANS recall).
module tb_key_entry_controller;
  logic sw_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  key_entry_controller_if bus();

  key_entry_controller #(.MAX_DIGITS(6), .CALC_LATENCY(1)) dut (
    .sw_clk (sw_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sw_clk = ~sw_clk;

  // Stand-in for calculate: registered result, one cycle behind its operands
  function automatic int calc_f(input int a, input int b, input int o);
    case (o)
      1: return a * b;
      2: return (b == 0) ? 0 : a / b;
      3: return a + b;
      4: return a - b;
      5: return (b == 0) ? 0 : a % b;
      default: return 0;
    endcase
  endfunction

  always_ff @(posedge sw_clk)
    bus.ans <= calc_f($signed(bus.operand1), $signed(bus.operand2), int'(bus.operator));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] k, input int hold);
    bus.eBCD = k;
    repeat (hold) @(posedge sw_clk);
    #1 bus.eBCD = 5'h1F;
    repeat (3) @(posedge sw_clk);
    #1;
  endtask

  task automatic press_glide(input logic [4:0] a, input logic [4:0] b);
    bus.eBCD = a;
    @(posedge sw_clk);
    #1 bus.eBCD = b;
    @(posedge sw_clk);
    #1 bus.eBCD = 5'h1F;
    repeat (3) @(posedge sw_clk);
    #1;
  endtask

  // ---------------- reference model: entry kept as a list of digits ----------------
  localparam int P_OP1 = 0, P_OPR = 1, P_OP2 = 2, P_RES = 3, P_ERR = 4;
  int q[$];
  bit m_neg;
  int m_phase, m_op1, m_op2, m_opr, m_fnd;

  function automatic int m_mag();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic int m_val();
    return m_neg ? -m_mag() : m_mag();
  endfunction

  function automatic int m_disp();
    if (m_neg && q.size() == 0) return int'(32'hE000_0000);
    return m_val();
  endfunction

  task automatic m_reset();
    q.delete(); m_neg = 0; m_phase = P_OP1;
    m_op1 = 0; m_op2 = 0; m_opr = 3; m_fnd = 0;
  endtask

  task automatic m_add(input int d);
    if (q.size() == 0 && d == 0) return;
    if (q.size() < (m_neg ? 5 : 6)) q.push_back(d);
  endtask

  task automatic m_toggle();
    if (m_neg) m_neg = 0;
    else if (q.size() <= 5) m_neg = 1;
  endtask

  task automatic model_key(input int k);
    int a;
    bit isop;
    isop = (k >= 17 && k <= 21);
    if (k == 24) begin m_reset(); return; end
    case (m_phase)
      P_OP1, P_OP2: begin
        if (k <= 9) begin m_add(k); m_fnd = m_disp(); end
        else if (k == 23) begin m_toggle(); m_fnd = m_disp(); end
        else if (isop && m_phase == P_OP1) begin
          m_op1 = m_val(); m_opr = k - 16; q.delete(); m_neg = 0;
          m_fnd = m_opr << 20; m_phase = P_OPR;
        end else if (k == 22 && m_phase == P_OP2) begin
          m_op2 = m_val();
          a = calc_f(m_op1, m_op2, m_opr);
          if (((m_opr == 2 || m_opr == 5) && m_op2 == 0) || a > 999999 || a < -99999) begin
            m_fnd = int'(32'h00EE_0000); m_phase = P_ERR;
          end else begin
            m_fnd = a; m_phase = P_RES;
          end
        end
      end
      P_OPR: begin
        if (isop) begin m_opr = k - 16; m_fnd = m_opr << 20; end
        else if (k <= 9) begin q.delete(); m_neg = 0; m_add(k); m_fnd = m_disp(); m_phase = P_OP2; end
        else if (k == 23) begin q.delete(); m_neg = 1; m_fnd = m_disp(); m_phase = P_OP2; end
      end
      P_RES: begin
        if (k <= 9) begin q.delete(); m_neg = 0; m_add(k); m_fnd = m_disp(); m_phase = P_OP1; end
        else if (isop) begin m_op1 = m_fnd; m_opr = k - 16; m_fnd = m_opr << 20; m_phase = P_OPR; end
      end
      default: ;
    endcase
  endtask

  function automatic logic [4:0] rand_key();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 55) return 5'($urandom_range(0, 9));
    if (r < 70) return 5'(16 + $urandom_range(1, 5));
    if (r < 78) return 5'h16;
    if (r < 86) return 5'h17;
    if (r < 90) return 5'h18;
    case ($urandom_range(0, 3))
      0: return 5'h10;
      1: return 5'h19;
      2: return 5'h1A;
      default: return 5'h1E;
    endcase
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_fnd"}, bus.fnd_serial, m_fnd);
    chk({tag, "_op1"}, bus.operand1, m_op1);
    chk({tag, "_opr"}, {29'd0, bus.operator}, m_opr);
    chk({tag, "_op2"}, bus.operand2, m_op2);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [4:0]  key;
    int          hold;
    logic [31:0] fnd;
    logic [31:0] op1;
    logic [2:0]  opr;
    logic [31:0] op2;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [4:0] k, k2;

    tbl = '{
      '{5'h01, 1, 32'd1,        32'd0,      3'd3, 32'd0},
      '{5'h02, 1, 32'd12,       32'd0,      3'd3, 32'd0},
      '{5'h03, 1, 32'd123,      32'd0,      3'd3, 32'd0},
      '{5'h13, 1, 32'h0030_0000, 32'd123,   3'd3, 32'd0},
      '{5'h04, 1, 32'd4,        32'd123,    3'd3, 32'd0},
      '{5'h05, 1, 32'd45,       32'd123,    3'd3, 32'd0},
      '{5'h16, 1, 32'd168,      32'd123,    3'd3, 32'd45},
      '{5'h18, 1, 32'd0,        32'd0,      3'd3, 32'd0},
      '{5'h01, 1, 32'd1,        32'd0,      3'd3, 32'd0},
      '{5'h02, 1, 32'd12,       32'd0,      3'd3, 32'd0},
      '{5'h03, 1, 32'd123,      32'd0,      3'd3, 32'd0},
      '{5'h04, 1, 32'd1234,     32'd0,      3'd3, 32'd0},
      '{5'h05, 1, 32'd12345,    32'd0,      3'd3, 32'd0},
      '{5'h06, 1, 32'd123456,   32'd0,      3'd3, 32'd0},
      '{5'h17, 1, 32'd123456,   32'd0,      3'd3, 32'd0},
      '{5'h18, 1, 32'd0,        32'd0,      3'd3, 32'd0},
      '{5'h17, 1, 32'hE000_0000, 32'd0,     3'd3, 32'd0},
      '{5'h07, 1, -32'sd7,      32'd0,      3'd3, 32'd0},
      '{5'h01, 1, -32'sd71,     32'd0,      3'd3, 32'd0},
      '{5'h02, 1, -32'sd712,    32'd0,      3'd3, 32'd0},
      '{5'h03, 1, -32'sd7123,   32'd0,      3'd3, 32'd0},
      '{5'h04, 1, -32'sd71234,  32'd0,      3'd3, 32'd0},
      '{5'h05, 1, -32'sd71234,  32'd0,      3'd3, 32'd0},
      '{5'h18, 1, 32'd0,        32'd0,      3'd3, 32'd0},
      '{5'h09, 1, 32'd9,        32'd0,      3'd3, 32'd0},
      '{5'h12, 1, 32'h0020_0000, 32'd9,     3'd2, 32'd0},
      '{5'h00, 1, 32'd0,        32'd9,      3'd2, 32'd0},
      '{5'h16, 1, 32'h00EE_0000, 32'd9,     3'd2, 32'd0},
      '{5'h05, 1, 32'h00EE_0000, 32'd9,     3'd2, 32'd0},
      '{5'h18, 1, 32'd0,        32'd0,      3'd3, 32'd0},
      '{5'h03, 10, 32'd3,       32'd0,      3'd3, 32'd0},
      '{5'h11, 1, 32'h0010_0000, 32'd3,     3'd1, 32'd0},
      '{5'h14, 1, 32'h0040_0000, 32'd3,     3'd4, 32'd0},
      '{5'h18, 1, 32'd0,        32'd0,      3'd3, 32'd0},
      '{5'h05, 1, 32'd5,        32'd0,      3'd3, 32'd0},
      '{5'h11, 1, 32'h0010_0000, 32'd5,     3'd1, 32'd0},
      '{5'h04, 1, 32'd4,        32'd5,      3'd1, 32'd0},
      '{5'h16, 1, 32'd20,       32'd5,      3'd1, 32'd4},
      '{5'h13, 1, 32'h0030_0000, 32'd20,    3'd3, 32'd4},
      '{5'h01, 1, 32'd1,        32'd20,     3'd3, 32'd4},
      '{5'h16, 1, 32'd21,       32'd20,     3'd3, 32'd1},
      '{5'h09, 1, 32'd9,        32'd20,     3'd3, 32'd1},
      '{5'h09, 1, 32'd99,       32'd20,     3'd3, 32'd1},
      '{5'h09, 1, 32'd999,      32'd20,     3'd3, 32'd1},
      '{5'h09, 1, 32'd9999,     32'd20,     3'd3, 32'd1},
      '{5'h09, 1, 32'd99999,    32'd20,     3'd3, 32'd1},
      '{5'h09, 1, 32'd999999,   32'd20,     3'd3, 32'd1},
      '{5'h11, 1, 32'h0010_0000, 32'd999999, 3'd1, 32'd1},
      '{5'h02, 1, 32'd2,        32'd999999, 3'd1, 32'd1},
      '{5'h16, 1, 32'h00EE_0000, 32'd999999, 3'd1, 32'd2},
      '{5'h18, 1, 32'd0,        32'd0,      3'd3, 32'd0}
    };

    // reset state
    rst = 1'b1;
    bus.eBCD = 5'h1F;
    repeat (3) @(posedge sw_clk);
    #1;
    chk("rst_fnd", bus.fnd_serial, 32'd0);
    chk("rst_op1", bus.operand1, 32'd0);
    chk("rst_op2", bus.operand2, 32'd0);
    chk("rst_opr", {29'd0, bus.operator}, 32'd3);
    rst = 1'b0;
    @(posedge sw_clk);
    #1;

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      press(tbl[i].key, tbl[i].hold);
      chk($sformatf("tbl%0d_fnd", i), bus.fnd_serial, tbl[i].fnd);
      chk($sformatf("tbl%0d_op1", i), bus.operand1, tbl[i].op1);
      chk($sformatf("tbl%0d_opr", i), {29'd0, bus.operator}, {29'd0, tbl[i].opr});
      chk($sformatf("tbl%0d_op2", i), bus.operand2, tbl[i].op2);
    end

    // result latency: not on the '=' edge, present within CALC_LATENCY+1 edges
    press(5'h01, 1);
    press(5'h13, 1);
    press(5'h02, 1);
    bus.eBCD = 5'h16;
    @(posedge sw_clk);
    #1;
    chk("lat_eq_edge_fnd", bus.fnd_serial, 32'd2);
    bus.eBCD = 5'h1F;
    @(posedge sw_clk);
    #1;
    chk("lat_hold_opr", {29'd0, bus.operator}, 32'd3);
    chk("lat_hold_op1", bus.operand1, 32'd1);
    chk("lat_hold_op2", bus.operand2, 32'd2);
    @(posedge sw_clk);
    #1;
    chk("lat_result", bus.fnd_serial, 32'd3);
    press(5'h18, 1);

    // code-to-code change without idle is ignored
    press_glide(5'h04, 5'h07);
    chk("glide_fnd", bus.fnd_serial, 32'd4);
    press(5'h07, 1);
    chk("glide_then_key", bus.fnd_serial, 32'd47);
    press(5'h18, 1);

    // rst the cycle after '=' discards the pending capture
    press(5'h01, 1);
    press(5'h13, 1);
    press(5'h02, 1);
    bus.eBCD = 5'h16;
    @(posedge sw_clk);
    #1;
    bus.eBCD = 5'h1F;
    rst = 1'b1;
    @(posedge sw_clk);
    #1;
    rst = 1'b0;
    chk("midrst_fnd", bus.fnd_serial, 32'd0);
    chk("midrst_opr", {29'd0, bus.operator}, 32'd3);
    chk("midrst_op1", bus.operand1, 32'd0);
    repeat (4) @(posedge sw_clk);
    #1;
    chk("midrst_no_ans", bus.fnd_serial, 32'd0);

    // randomized key stream against the model
    m_reset();
    for (int n = 0; n < 300; n++) begin
      k = rand_key();
      if ($urandom_range(0, 9) == 0) begin
        k2 = 5'($urandom_range(0, 9));
        press_glide(k, k2);
      end else begin
        press(k, int'($urandom_range(1, 3)));
      end
      model_key(int'(k));
      chk_model($sformatf("rnd%0d_k%02h", n, k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
